// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback-side signal bundle for the load hazard scoreboard.
// The pipeline drives through master; the scoreboard sits on slave.
interface hazard_scoreboard_if #(
    parameter int NREG = 16
);
    localparam int RW = $clog2(NREG);

    logic            IDvalid;
    logic [RW-1:0]   IDreadReg1;
    logic [RW-1:0]   IDreadReg2;
    logic            IDuses1;
    logic            IDuses2;
    logic            IDRegWrite;
    logic [RW-1:0]   IDwriteReg;
    logic            IDisLoad;
    logic            WBvalid;
    logic [RW-1:0]   WBwriteReg;
    logic            WBisLoad;
    logic            flush;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] pendingMask;
    logic [2:0]      loadCount;
    logic            draining;
    logic            wbError;

    modport master (
        output IDvalid, IDreadReg1, IDreadReg2, IDuses1, IDuses2,
               IDRegWrite, IDwriteReg, IDisLoad,
               WBvalid, WBwriteReg, WBisLoad, flush,
        input  stall, issue, pendingMask, loadCount, draining, wbError
    );

    modport slave (
        input  IDvalid, IDreadReg1, IDreadReg2, IDuses1, IDuses2,
               IDRegWrite, IDwriteReg, IDisLoad,
               WBvalid, WBwriteReg, WBisLoad, flush,
        output stall, issue, pendingMask, loadCount, draining, wbError
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks outstanding long-latency register writes from issue to writeback,
// stalling decode on RAW/WAW hazards, a full load window, and during flush drain.
module hazard_scoreboard #(
    parameter int NREG      = 16,
    parameter int MAX_LOADS = 4
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          state_q;
    logic [NREG-1:0] mask_q, mask_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            draining_q;
    logic            wb_err_q;

    logic [NREG-1:0] eff_mask, clr_vec, set_vec;
    logic [2:0]      eff_cnt;
    logic            wb_act, wb_bad, wb_ok, wb_dec;
    logic            raw1, raw2, waw, lfull, stall, issue, do_set;

    always_comb begin
        wb_act  = sb.WBvalid && (sb.WBwriteReg != '0);
        // A completion for a write that is not outstanding is rejected whole.
        wb_bad  = wb_act && (!mask_q[sb.WBwriteReg] || (sb.WBisLoad && cnt_q == 3'd0));
        wb_ok   = wb_act && !wb_bad;
        wb_dec  = wb_ok && sb.WBisLoad;

        clr_vec = '0;
        if (wb_ok) clr_vec[sb.WBwriteReg] = 1'b1;
        // Register file writes before decode reads, so completions release now.
        eff_mask = mask_q & ~clr_vec;
        eff_cnt  = cnt_q - {2'b00, wb_dec};

        raw1  = sb.IDvalid && sb.IDuses1 && (sb.IDreadReg1 != '0) && eff_mask[sb.IDreadReg1];
        raw2  = sb.IDvalid && sb.IDuses2 && (sb.IDreadReg2 != '0) && eff_mask[sb.IDreadReg2];
        waw   = sb.IDvalid && sb.IDRegWrite && (sb.IDwriteReg != '0) && eff_mask[sb.IDwriteReg];
        lfull = sb.IDvalid && sb.IDisLoad && sb.IDRegWrite && (eff_cnt == 3'(MAX_LOADS));

        stall = draining_q || sb.flush || raw1 || raw2 || waw || lfull;
        issue = sb.IDvalid && !stall;

        do_set  = issue && sb.IDRegWrite && sb.IDisLoad && (sb.IDwriteReg != '0);
        set_vec = '0;
        if (do_set) set_vec[sb.IDwriteReg] = 1'b1;

        // Set after clear: a same-register set/clear leaves the bit pending.
        mask_d = eff_mask | set_vec;
        cnt_d  = cnt_q + {2'b00, do_set} - {2'b00, wb_dec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cnt_q      <= 3'd0;
            draining_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_bad;
            case (state_q)
                IDLE, BUSY: begin
                    if (sb.flush) begin
                        state_q    <= DRAIN;
                        draining_q <= 1'b1;
                    end else begin
                        state_q    <= (mask_d != '0) ? BUSY : IDLE;
                        draining_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Leave once every outstanding write has landed.
                    if (!sb.flush && mask_d == '0 && cnt_d == 3'd0) begin
                        state_q    <= IDLE;
                        draining_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    draining_q <= 1'b0;
                end
            endcase
        end
    end

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.pendingMask = mask_q;
    assign sb.loadCount   = cnt_q;
    assign sb.draining    = draining_q;
    assign sb.wbError     = wb_err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard: each row drives one cycle
// and checks stall/issue plus the registered state seen at the start of that cycle.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(16)) sb ();

    hazard_scoreboard #(.NREG(16), .MAX_LOADS(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb.slave)
    );

    typedef struct packed {
        logic        idv;
        logic [3:0]  rs1;
        logic        u1;
        logic [3:0]  rs2;
        logic        u2;
        logic        rw;
        logic [3:0]  wr;
        logic        ld;
        logic        wbv;
        logic [3:0]  wbr;
        logic        wbl;
        logic        fl;
        logic        e_stall;
        logic        e_issue;
        logic [15:0] e_mask;
        logic [2:0]  e_cnt;
        logic        e_dr;
        logic        e_err;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    vec_t tbl[$];

    function automatic vec_t v(input int idv, rs1, u1, rs2, u2, rw, wr, ld,
                               input int wbv, wbr, wbl, fl,
                               input int st, is, mk, cn, dr, er);
        vec_t t;
        t.idv = 1'(idv);   t.rs1 = 4'(rs1);  t.u1 = 1'(u1);
        t.rs2 = 4'(rs2);   t.u2 = 1'(u2);    t.rw = 1'(rw);
        t.wr = 4'(wr);     t.ld = 1'(ld);    t.wbv = 1'(wbv);
        t.wbr = 4'(wbr);   t.wbl = 1'(wbl);  t.fl = 1'(fl);
        t.e_stall = 1'(st); t.e_issue = 1'(is); t.e_mask = 16'(mk);
        t.e_cnt = 3'(cn);  t.e_dr = 1'(dr);  t.e_err = 1'(er);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t t);
        sb.IDvalid = t.idv;   sb.IDreadReg1 = t.rs1; sb.IDuses1 = t.u1;
        sb.IDreadReg2 = t.rs2; sb.IDuses2 = t.u2;    sb.IDRegWrite = t.rw;
        sb.IDwriteReg = t.wr; sb.IDisLoad = t.ld;    sb.WBvalid = t.wbv;
        sb.WBwriteReg = t.wbr; sb.WBisLoad = t.wbl;  sb.flush = t.fl;
    endtask

    task automatic check_outs(input string tag, input vec_t t);
        chk({tag, " stall"},    32'(sb.stall),       32'(t.e_stall));
        chk({tag, " issue"},    32'(sb.issue),       32'(t.e_issue));
        chk({tag, " mask"},     32'(sb.pendingMask), 32'(t.e_mask));
        chk({tag, " count"},    32'(sb.loadCount),   32'(t.e_cnt));
        chk({tag, " draining"}, 32'(sb.draining),    32'(t.e_dr));
        chk({tag, " wbError"},  32'(sb.wbError),     32'(t.e_err));
    endtask

    task automatic apply(input string tag, input vec_t t);
        drive(t);
        @(negedge clk);
        check_outs(tag, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idv rs1 u1 rs2 u2 rw wr ld | wbv wbr wbl fl | stall issue mask cnt dr err
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,5,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,5,1,0,0,0,0,0, 0,0,0,0, 1,0,'h0020,1,0,0));
        tbl.push_back(v(1,5,1,0,0,0,0,0, 0,0,0,0, 1,0,'h0020,1,0,0));
        tbl.push_back(v(1,5,1,0,0,0,0,0, 1,5,1,0, 0,1,'h0020,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,0,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,7,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,7,0,7,0,0,0,0, 0,0,0,0, 0,1,'h0080,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,0,1,0, 0,0,'h0080,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0080,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,7,1,0, 0,0,'h0080,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,1,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,2,1, 0,0,0,0, 0,1,'h0002,1,0,0));
        tbl.push_back(v(1,0,0,0,0,1,3,1, 0,0,0,0, 0,1,'h0006,2,0,0));
        tbl.push_back(v(1,0,0,0,0,1,4,1, 0,0,0,0, 0,1,'h000E,3,0,0));
        tbl.push_back(v(1,0,0,0,0,1,6,1, 0,0,0,0, 1,0,'h001E,4,0,0));
        tbl.push_back(v(1,0,0,0,0,1,6,1, 1,1,1,0, 0,1,'h001E,4,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h005C,4,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,2,1,0, 0,0,'h005C,4,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,3,1,0, 0,0,'h0058,3,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,4,1,0, 0,0,'h0050,2,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,6,1,0, 0,0,'h0040,1,0,0));
        tbl.push_back(v(1,0,0,0,0,1,9,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,9,1, 0,0,0,0, 1,0,'h0200,1,0,0));
        tbl.push_back(v(1,0,0,0,0,1,9,1, 1,9,1,0, 0,1,'h0200,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0200,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,3,1,0, 0,0,'h0200,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0200,1,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0200,1,0,0));
        tbl.push_back(v(1,0,0,9,1,0,0,0, 0,0,0,0, 1,0,'h0200,1,0,0));
        tbl.push_back(v(1,0,0,9,1,0,0,0, 1,9,1,0, 0,1,'h0200,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0000,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 1,3,1,0, 0,0,'h0000,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h0000,0,0,1));

        rst_n = 1'b0;
        drive(v(1,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,1,'h0000,0,0,0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("row%0d", i), tbl[i]);

        // Flush with two loads outstanding: stall holds until both complete.
        apply("fl_a", v(1,0,0,0,0,1,10,1, 0,0,0,0,  0,1,'h0000,0,0,0));
        apply("fl_b", v(1,0,0,0,0,1,11,1, 0,0,0,0,  0,1,'h0400,1,0,0));
        apply("fl_c", v(1,1,1,0,0,0,0,0,  0,0,0,1,  1,0,'h0C00,2,0,0));
        apply("fl_d", v(1,1,1,0,0,0,0,0,  0,0,0,0,  1,0,'h0C00,2,1,0));
        apply("fl_e", v(1,1,1,0,0,0,0,0,  1,10,1,0, 1,0,'h0C00,2,1,0));
        apply("fl_f", v(1,1,1,0,0,0,0,0,  1,11,1,0, 1,0,'h0800,1,1,0));
        apply("fl_g", v(1,1,1,0,0,0,0,0,  0,0,0,0,  0,1,'h0000,0,0,0));

        // Flush on an empty mask, then a second flush while already draining.
        apply("fe_h", v(1,1,1,0,0,0,0,0, 0,0,0,1, 1,0,'h0000,0,0,0));
        apply("fe_i", v(1,1,1,0,0,0,0,0, 0,0,0,1, 1,0,'h0000,0,1,0));
        apply("fe_j", v(1,1,1,0,0,0,0,0, 0,0,0,0, 1,0,'h0000,0,1,0));
        apply("fe_k", v(1,1,1,0,0,0,0,0, 0,0,0,0, 0,1,'h0000,0,0,0));

        // Asynchronous reset in the middle of a drain.
        apply("ar_a", v(1,0,0,0,0,1,12,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        apply("ar_b", v(1,0,0,0,0,1,13,1, 0,0,0,0, 0,1,'h1000,1,0,0));
        apply("ar_c", v(0,0,0,0,0,0,0,0,  0,0,0,1, 1,0,'h3000,2,0,0));
        drive(v(1,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        #2;
        chk("ar_pre draining", 32'(sb.draining), 32'd1);
        chk("ar_pre mask", 32'(sb.pendingMask), 32'h3000);
        rst_n = 1'b0;
        #1;
        check_outs("ar_rst", v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,1,'h0000,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply("ar_post", v(1,0,0,0,0,1,14,1, 0,0,0,0, 0,1,'h0000,0,0,0));
        apply("ar_post2", v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h4000,1,0,0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
